// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Holds the port-ownership state encoding and the load/store size codes.
package dmem_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN,
    HALTED,
    WR_COLLECT,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic is_burst_access(state_e s);
    return (s == WR_ISSUE) || (s == RD_ISSUE);
  endfunction

endpackage

// File: rtl/dmem_burst_counter.sv
// Address and remaining-length tracking for debug bursts.
// Steps by one word, or by two for a packed pair write; the address wraps modulo 2^ADDR_W.
module dmem_burst_counter #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              advance,
  input  logic              pair,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              single_left
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = start_addr;
      rem_d  = start_len;
    end else if (advance) begin
      if (pair) begin
        addr_d = addr_q + ADDR_W'(2);
        rem_d  = rem_q - LEN_W'(2);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  // "last" means the step taken this cycle empties the burst.
  assign addr        = addr_q;
  assign single_left = (rem_q == LEN_W'(1));
  assign last        = pair ? (rem_q == LEN_W'(2)) : (rem_q == LEN_W'(1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates the single data-memory port between the core MEM stage and the debug unit.
// Core accesses pass straight through; a debug halt stalls the core and runs packed write or read bursts.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_funct3,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_halt_req,
  output logic              dbg_halted,
  input  logic              dbg_cmd_valid,
  output logic              dbg_cmd_ready,
  input  logic              dbg_cmd_write,
  input  logic [ADDR_W-1:0] dbg_cmd_addr,
  input  logic [LEN_W-1:0]  dbg_cmd_len,
  input  logic              dbg_wdata_valid,
  output logic              dbg_wdata_ready,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_rdata_valid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic [DATA_W-1:0] mem_wd2,
  output logic [2:0]        mem_funct3,
  output logic              mem_enable_halt,
  input  logic [DATA_W-1:0] mem_rd
);

  state_e            state_q, state_d;
  logic              core_stall_q, core_stall_d;
  logic              dbg_halted_q, dbg_halted_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] word0_q, word0_d;
  logic [DATA_W-1:0] word1_q, word1_d;
  logic              have_word0_q, have_word0_d;

  logic              cmd_accept;
  logic              wdata_accept;
  logic              pair_issue;
  logic [ADDR_W-1:0] burst_addr;
  logic              burst_last;
  logic              single_left;

  assign cmd_accept   = (state_q == HALTED) && dbg_cmd_valid;
  assign wdata_accept = (state_q == WR_COLLECT) && dbg_wdata_valid;
  assign pair_issue   = (state_q == WR_ISSUE) && !single_left;

  dmem_burst_counter #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cmd_accept),
    .start_addr (dbg_cmd_addr),
    .start_len  (dbg_cmd_len),
    .advance    (is_burst_access(state_q)),
    .pair       (pair_issue),
    .addr       (burst_addr),
    .last       (burst_last),
    .single_left(single_left)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      core_stall_q  <= 1'b0;
      dbg_halted_q  <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      word0_q       <= '0;
      word1_q       <= '0;
      have_word0_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      core_stall_q  <= core_stall_d;
      dbg_halted_q  <= dbg_halted_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      word0_q       <= word0_d;
      word1_q       <= word1_d;
      have_word0_q  <= have_word0_d;
    end
  end

  // Once a burst starts it runs to DONE; dropping the halt request only matters at DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:        if (dbg_halt_req) state_d = HALTED;
      HALTED: begin
        if (dbg_cmd_valid) begin
          if (dbg_cmd_len == '0)  state_d = DONE;
          else if (dbg_cmd_write) state_d = WR_COLLECT;
          else                    state_d = RD_ISSUE;
        end else if (!dbg_halt_req) begin
          state_d = RUN;
        end
      end
      WR_COLLECT: if (dbg_wdata_valid && (have_word0_q || single_left)) state_d = WR_ISSUE;
      WR_ISSUE:   state_d = burst_last ? DONE : WR_COLLECT;
      RD_ISSUE:   if (burst_last) state_d = RD_WAIT;
      RD_WAIT:    state_d = DONE;
      DONE:       state_d = dbg_halt_req ? HALTED : RUN;
      default:    state_d = RUN;
    endcase
  end

  always_comb begin
    core_stall_d  = (state_d != RUN);
    dbg_halted_d  = (state_d != RUN);
    rdata_valid_d = (state_q == RD_ISSUE);
    rdata_d       = (state_q == RD_ISSUE) ? mem_rd : rdata_q;
    word0_d       = word0_q;
    word1_d       = word1_q;
    have_word0_d  = have_word0_q;
    if (cmd_accept || (state_q == WR_ISSUE)) begin
      have_word0_d = 1'b0;
    end else if (wdata_accept) begin
      if (have_word0_q) begin
        word1_d = dbg_wdata;
      end else begin
        word0_d      = dbg_wdata;
        have_word0_d = 1'b1;
      end
    end
  end

  // The memory port is forced idle while rst_n is low so a core request cannot leak through reset.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_a           = '0;
    mem_wd          = '0;
    mem_wd2         = '0;
    mem_funct3      = 3'b000;
    mem_enable_halt = 1'b0;
    dbg_cmd_ready   = (state_q == HALTED);
    dbg_wdata_ready = (state_q == WR_COLLECT);
    dbg_done        = (state_q == DONE);
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          mem_read   = core_mem_read;
          mem_write  = core_mem_write;
          mem_a      = core_addr;
          mem_wd     = core_wdata;
          mem_funct3 = core_funct3;
        end
        WR_ISSUE: begin
          mem_write       = 1'b1;
          mem_funct3      = F3_SW;
          mem_a           = burst_addr;
          mem_wd          = word0_q;
          mem_wd2         = pair_issue ? word1_q : '0;
          mem_enable_halt = pair_issue;
        end
        RD_ISSUE: begin
          mem_read   = 1'b1;
          mem_funct3 = F3_LW;
          mem_a      = burst_addr;
        end
        default: ;
      endcase
    end
  end

  assign core_rdata      = mem_rd;
  assign core_stall      = core_stall_q;
  assign dbg_halted      = dbg_halted_q;
  assign dbg_rdata_valid = rdata_valid_q;
  assign dbg_rdata       = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl with a behavioural data memory.
// Burst tasks queue expected memory transactions and read data, then pop them as the DUT produces them.
module tb_dmem_access_ctrl;

   typedef struct packed {
      logic        pair;
      logic [8:0]  a;
      logic [31:0] wd;
      logic [31:0] wd2;
   } wr_exp_t;

   logic        clk;
   logic        rst_n;
   logic        core_mem_read, core_mem_write;
   logic [8:0]  core_addr;
   logic [31:0] core_wdata;
   logic [2:0]  core_funct3;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic        dbg_halt_req, dbg_halted;
   logic        dbg_cmd_valid, dbg_cmd_ready, dbg_cmd_write;
   logic [8:0]  dbg_cmd_addr;
   logic [9:0]  dbg_cmd_len;
   logic        dbg_wdata_valid, dbg_wdata_ready;
   logic [31:0] dbg_wdata;
   logic        dbg_rdata_valid;
   logic [31:0] dbg_rdata;
   logic        dbg_done;
   logic        mem_read, mem_write, mem_enable_halt;
   logic [8:0]  mem_a;
   logic [31:0] mem_wd, mem_wd2, mem_rd;
   logic [2:0]  mem_funct3;

   int passed = 0;
   int total  = 0;

   logic [31:0] mem_arr [0:511];

   dmem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_funct3(core_funct3),
      .core_rdata(core_rdata), .core_stall(core_stall),
      .dbg_halt_req(dbg_halt_req), .dbg_halted(dbg_halted),
      .dbg_cmd_valid(dbg_cmd_valid), .dbg_cmd_ready(dbg_cmd_ready),
      .dbg_cmd_write(dbg_cmd_write), .dbg_cmd_addr(dbg_cmd_addr), .dbg_cmd_len(dbg_cmd_len),
      .dbg_wdata_valid(dbg_wdata_valid), .dbg_wdata_ready(dbg_wdata_ready), .dbg_wdata(dbg_wdata),
      .dbg_rdata_valid(dbg_rdata_valid), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
      .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a),
      .mem_wd(mem_wd), .mem_wd2(mem_wd2), .mem_funct3(mem_funct3),
      .mem_enable_halt(mem_enable_halt), .mem_rd(mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational-read memory; pair mode writes wd2 to the wrapped next word.
   assign mem_rd = mem_arr[mem_a];
   always @(posedge clk) begin
      if (mem_write) begin
         mem_arr[mem_a] <= mem_wd;
         if (mem_enable_halt) mem_arr[9'(mem_a + 9'd1)] <= mem_wd2;
      end
   end

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      total++; if (core_stall !== 1'b0) $display("[TB] FAIL rst_stall: got %b expected 0", core_stall); else passed++;
      total++; if (dbg_halted !== 1'b0) $display("[TB] FAIL rst_halted: got %b expected 0", dbg_halted); else passed++;
      total++; if (dbg_cmd_ready !== 1'b0) $display("[TB] FAIL rst_cmd_ready: got %b expected 0", dbg_cmd_ready); else passed++;
      total++; if (mem_write !== 1'b0) $display("[TB] FAIL rst_mem_write: got %b expected 0", mem_write); else passed++;
      total++; if (mem_a !== 9'd0) $display("[TB] FAIL rst_mem_a: got %0d expected 0", mem_a); else passed++;
      total++; if (mem_wd !== 32'd0) $display("[TB] FAIL rst_mem_wd: got %h expected 0", mem_wd); else passed++;
      total++; if (dbg_done !== 1'b0 || dbg_rdata_valid !== 1'b0) $display("[TB] FAIL rst_dbg_strobes: got %b%b expected 00", dbg_done, dbg_rdata_valid); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      core_mem_write = 1'b0;
   endtask

   task automatic test_run_passthrough();
      @(negedge clk);
      core_mem_write = 1'b1; core_addr = 9'd5; core_wdata = 32'hDEADBEEF; core_funct3 = 3'b010;
      #1;
      total++; if (mem_write !== 1'b1 || mem_a !== 9'd5) $display("[TB] FAIL run_sw_port: got we=%b a=%0d expected we=1 a=5", mem_write, mem_a); else passed++;
      total++; if (mem_wd !== 32'hDEADBEEF || mem_funct3 !== 3'b010) $display("[TB] FAIL run_sw_data: got %h/%b expected deadbeef/010", mem_wd, mem_funct3); else passed++;
      total++; if (mem_enable_halt !== 1'b0 || core_stall !== 1'b0) $display("[TB] FAIL run_sw_mode: got eh=%b stall=%b expected 0/0", mem_enable_halt, core_stall); else passed++;
      @(negedge clk);
      core_mem_write = 1'b0; core_mem_read = 1'b1; core_addr = 9'd5;
      #1;
      total++; if (mem_read !== 1'b1 || mem_a !== 9'd5) $display("[TB] FAIL run_lw_port: got re=%b a=%0d expected re=1 a=5", mem_read, mem_a); else passed++;
      total++; if (core_rdata !== 32'hDEADBEEF) $display("[TB] FAIL run_lw_data: got %h expected deadbeef", core_rdata); else passed++;
      total++; if (core_stall !== 1'b0) $display("[TB] FAIL run_lw_stall: got %b expected 0", core_stall); else passed++;
   endtask

   task automatic test_halt();
      @(negedge clk);
      core_mem_read = 1'b1; core_addr = 9'd5; dbg_halt_req = 1'b1;
      #1;
      total++; if (mem_read !== 1'b1 || core_rdata !== 32'hDEADBEEF) $display("[TB] FAIL halt_same_cycle_lw: got re=%b rd=%h expected 1/deadbeef", mem_read, core_rdata); else passed++;
      total++; if (core_stall !== 1'b0 || dbg_halted !== 1'b0) $display("[TB] FAIL halt_not_yet: got %b%b expected 00", core_stall, dbg_halted); else passed++;
      @(negedge clk);
      core_addr = 9'd6;
      #1;
      total++; if (core_stall !== 1'b1 || dbg_halted !== 1'b1) $display("[TB] FAIL halt_flags: got %b%b expected 11", core_stall, dbg_halted); else passed++;
      total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("[TB] FAIL halt_mem_idle: got %b%b expected 00", mem_read, mem_write); else passed++;
      total++; if (dbg_cmd_ready !== 1'b1) $display("[TB] FAIL halt_cmd_ready: got %b expected 1", dbg_cmd_ready); else passed++;
      core_mem_read = 1'b0;
   endtask

   task automatic test_write_burst();
      wr_exp_t     wq[$];
      wr_exp_t     e;
      logic [31:0] data [5];
      int idx = 0, done_cnt = 0, cyc = 0, done_cyc = -1;
      bit cmd_pending = 1'b1;
      data = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
      wq.push_back('{pair: 1'b1, a: 9'd10, wd: 32'd1, wd2: 32'd2});
      wq.push_back('{pair: 1'b1, a: 9'd12, wd: 32'd3, wd2: 32'd4});
      wq.push_back('{pair: 1'b0, a: 9'd14, wd: 32'd5, wd2: 32'd0});
      while (cyc < 60 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
         @(negedge clk);
         dbg_cmd_valid = cmd_pending; dbg_cmd_write = 1'b1; dbg_cmd_addr = 9'd10; dbg_cmd_len = 10'd5;
         dbg_wdata_valid = (idx < 5);
         dbg_wdata = data[(idx < 5) ? idx : 0];
         #1;
         if (cmd_pending && dbg_cmd_ready) cmd_pending = 1'b0;
         if (dbg_wdata_valid && dbg_wdata_ready) idx++;
         if (mem_write) begin
            if (wq.size() == 0) begin
               total++; $display("[TB] FAIL wr_unexpected: got write a=%0d expected none", mem_a);
            end else begin
               e = wq.pop_front();
               total++; if (mem_enable_halt !== e.pair) $display("[TB] FAIL wr_pair_mode: got %b expected %b", mem_enable_halt, e.pair); else passed++;
               total++; if (mem_a !== e.a) $display("[TB] FAIL wr_addr: got %0d expected %0d", mem_a, e.a); else passed++;
               total++; if (mem_wd !== e.wd || mem_funct3 !== 3'b010) $display("[TB] FAIL wr_wd: got %h/%b expected %h/010", mem_wd, mem_funct3, e.wd); else passed++;
               if (e.pair) begin
                  total++; if (mem_wd2 !== e.wd2) $display("[TB] FAIL wr_wd2: got %h expected %h", mem_wd2, e.wd2); else passed++;
               end
            end
         end
         if (mem_read) begin
            total++; $display("[TB] FAIL wr_stray_read: got read a=%0d expected none", mem_a);
         end
         if (dbg_done) begin done_cnt++; done_cyc = cyc; end
         cyc++;
      end
      dbg_cmd_valid = 1'b0; dbg_wdata_valid = 1'b0;
      total++; if (done_cnt !== 1) $display("[TB] FAIL wr_done_count: got %0d expected 1", done_cnt); else passed++;
      total++; if (wq.size() !== 0) $display("[TB] FAIL wr_missing: got %0d outstanding expected 0", wq.size()); else passed++;
      for (int i = 0; i < 5; i++) begin
         total++; if (mem_arr[10 + i] !== 32'(i + 1)) $display("[TB] FAIL wr_mem_content: got %h at %0d expected %h", mem_arr[10 + i], 10 + i, i + 1); else passed++;
      end
   endtask

   task automatic test_read_burst();
      logic [8:0]  aq[$];
      logic [31:0] dq[$];
      int          iq[$];
      logic [8:0]  start;
      int done_cnt = 0, cyc = 0, done_cyc = -1, last_valid = -1, ic;
      bit cmd_pending = 1'b1;
      start = 9'd510;
      for (int i = 0; i < 4; i++) begin
         aq.push_back(9'(start + 9'(i)));
         dq.push_back(32'hA500_0000 | 32'(9'(start + 9'(i))));
      end
      while (cyc < 40 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
         @(negedge clk);
         dbg_cmd_valid = cmd_pending; dbg_cmd_write = 1'b0; dbg_cmd_addr = start; dbg_cmd_len = 10'd4;
         #1;
         if (cmd_pending && dbg_cmd_ready) cmd_pending = 1'b0;
         if (mem_read) begin
            if (aq.size() == 0) begin
               total++; $display("[TB] FAIL rd_unexpected_issue: got a=%0d expected none", mem_a);
            end else begin
               total++; if (mem_a !== aq[0]) $display("[TB] FAIL rd_issue_addr: got %0d expected %0d", mem_a, aq[0]); else passed++;
               void'(aq.pop_front());
               iq.push_back(cyc);
            end
         end
         if (mem_write) begin
            total++; $display("[TB] FAIL rd_stray_write: got write a=%0d expected none", mem_a);
         end
         if (dbg_rdata_valid) begin
            if (dq.size() == 0 || iq.size() == 0) begin
               total++; $display("[TB] FAIL rd_unexpected_data: got %h expected none", dbg_rdata);
            end else begin
               ic = iq.pop_front();
               total++; if (dbg_rdata !== dq[0]) $display("[TB] FAIL rd_data: got %h expected %h", dbg_rdata, dq[0]); else passed++;
               total++; if (cyc !== ic + 1) $display("[TB] FAIL rd_latency: got cycle %0d expected %0d", cyc, ic + 1); else passed++;
               void'(dq.pop_front());
               last_valid = cyc;
            end
         end
         if (dbg_done) begin done_cnt++; done_cyc = cyc; end
         cyc++;
      end
      dbg_cmd_valid = 1'b0;
      total++; if (done_cnt !== 1) $display("[TB] FAIL rd_done_count: got %0d expected 1", done_cnt); else passed++;
      total++; if (dq.size() !== 0 || aq.size() !== 0) $display("[TB] FAIL rd_missing: got %0d/%0d outstanding expected 0/0", aq.size(), dq.size()); else passed++;
      total++; if (!(last_valid >= 0 && done_cyc > last_valid)) $display("[TB] FAIL rd_done_order: got done %0d last data %0d expected done later", done_cyc, last_valid); else passed++;
   endtask

   task automatic test_zero_len_and_release();
      int done_cnt = 0, done_cyc = -1, accessed = 0;
      @(negedge clk);
      dbg_cmd_valid = 1'b1; dbg_cmd_write = 1'b0; dbg_cmd_addr = 9'd3; dbg_cmd_len = 10'd0;
      #1;
      total++; if (dbg_cmd_ready !== 1'b1) $display("[TB] FAIL zl_accept: got %b expected 1", dbg_cmd_ready); else passed++;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         dbg_cmd_valid = 1'b0;
         #1;
         if (mem_read || mem_write) accessed++;
         if (dbg_done) begin done_cnt++; done_cyc = cyc; end
      end
      total++; if (accessed !== 0) $display("[TB] FAIL zl_mem_access: got %0d accesses expected 0", accessed); else passed++;
      total++; if (done_cnt !== 1 || done_cyc !== 1) $display("[TB] FAIL zl_done: got count %0d cycle %0d expected 1/1", done_cnt, done_cyc); else passed++;
      @(negedge clk);
      dbg_halt_req = 1'b0;
      @(negedge clk);
      #1;
      total++; if (core_stall !== 1'b0 || dbg_halted !== 1'b0) $display("[TB] FAIL release_flags: got %b%b expected 00", core_stall, dbg_halted); else passed++;
      @(negedge clk);
      core_mem_read = 1'b1; core_addr = 9'd12; core_funct3 = 3'b010;
      #1;
      total++; if (mem_read !== 1'b1 || core_rdata !== 32'd3) $display("[TB] FAIL release_core_lw: got re=%b rd=%h expected 1/00000003", mem_read, core_rdata); else passed++;
      @(negedge clk);
      core_mem_read = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      int done_cnt = 0, stall_cnt = 0;
      @(negedge clk);
      dbg_halt_req = 1'b1;
      @(negedge clk);
      dbg_cmd_valid = 1'b1; dbg_cmd_write = 1'b1; dbg_cmd_addr = 9'd20; dbg_cmd_len = 10'd4;
      #1;
      total++; if (dbg_cmd_ready !== 1'b1) $display("[TB] FAIL mid_cmd_ready: got %b expected 1", dbg_cmd_ready); else passed++;
      @(negedge clk);
      dbg_cmd_valid = 1'b0; dbg_wdata_valid = 1'b1; dbg_wdata = 32'h77;
      #1;
      total++; if (dbg_wdata_ready !== 1'b1) $display("[TB] FAIL mid_wdata_ready: got %b expected 1", dbg_wdata_ready); else passed++;
      @(negedge clk);
      dbg_wdata_valid = 1'b0; dbg_halt_req = 1'b0; rst_n = 1'b0;
      core_mem_write = 1'b1; core_addr = 9'd9; core_wdata = 32'h55; core_funct3 = 3'b010;
      #1;
      total++; if (core_stall !== 1'b0 || dbg_halted !== 1'b0) $display("[TB] FAIL mid_rst_flags: got %b%b expected 00", core_stall, dbg_halted); else passed++;
      total++; if (dbg_cmd_ready !== 1'b0 || dbg_wdata_ready !== 1'b0) $display("[TB] FAIL mid_rst_ready: got %b%b expected 00", dbg_cmd_ready, dbg_wdata_ready); else passed++;
      total++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_enable_halt !== 1'b0) $display("[TB] FAIL mid_rst_mem_ctl: got %b%b%b expected 000", mem_write, mem_read, mem_enable_halt); else passed++;
      total++; if (mem_a !== 9'd0 || mem_wd !== 32'd0 || mem_wd2 !== 32'd0 || mem_funct3 !== 3'b000) $display("[TB] FAIL mid_rst_mem_bus: got a=%0d wd=%h wd2=%h f3=%b expected zeros", mem_a, mem_wd, mem_wd2, mem_funct3); else passed++;
      total++; if (dbg_done !== 1'b0 || dbg_rdata_valid !== 1'b0) $display("[TB] FAIL mid_rst_strobes: got %b%b expected 00", dbg_done, dbg_rdata_valid); else passed++;
      @(negedge clk);
      rst_n = 1'b1; core_mem_write = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (dbg_done) done_cnt++;
         if (core_stall) stall_cnt++;
      end
      total++; if (done_cnt !== 0) $display("[TB] FAIL mid_no_done: got %0d pulses expected 0", done_cnt); else passed++;
      total++; if (stall_cnt !== 0) $display("[TB] FAIL mid_stall_after: got %0d stalled cycles expected 0", stall_cnt); else passed++;
      @(negedge clk);
      core_mem_write = 1'b1; core_addr = 9'd9; core_wdata = 32'h55;
      #1;
      total++; if (mem_write !== 1'b1 || mem_a !== 9'd9 || mem_wd !== 32'h55) $display("[TB] FAIL mid_run_passthrough: got we=%b a=%0d wd=%h expected 1/9/55", mem_write, mem_a, mem_wd); else passed++;
      @(negedge clk);
      core_mem_write = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem_arr[i] <= 32'hA500_0000 | 32'(i);
      rst_n = 1'b0;
      core_mem_read = 1'b0; core_mem_write = 1'b1; core_addr = 9'd7; core_wdata = 32'h1234; core_funct3 = 3'b010;
      dbg_halt_req = 1'b0; dbg_cmd_valid = 1'b0; dbg_cmd_write = 1'b0; dbg_cmd_addr = '0; dbg_cmd_len = '0;
      dbg_wdata_valid = 1'b0; dbg_wdata = '0;
      $display("[TB] starting dmem_access_ctrl bench");
      test_reset();
      test_run_passthrough();
      test_halt();
      test_write_burst();
      test_read_burst();
      test_zero_len_and_release();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Owns the single data-memory port and shares it between the pipeline MEM stage (core) and the debug unit.
- Core accesses pass straight through while the block is running.
- A debug halt stalls the core and switches the port to debug-driven bursts. Write bursts are packed two words per cycle using the memory's secondary write-data path, to speed up memory init. Read bursts return one word per cycle for readback.

Parameters:
- ADDR_W, 9, data-memory word address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, data word width.
- LEN_W, 10, burst length width in words; maximum length is 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_mem_read  in  1  MemRead from the MEM stage
- core_mem_write  in  1  MemWrite from the MEM stage
- core_addr  in  ADDR_W  core address (ALU LSBs)
- core_wdata  in  DATA_W  core store data
- core_funct3  in  3  load/store size code
- core_rdata  out  DATA_W  load data to the MEM stage (mem_rd passthrough)
- core_stall  out  1  registered; freezes the pipeline
- dbg_halt_req  in  1  level request for the port
- dbg_halted  out  1  registered; the port is owned by debug
- dbg_cmd_valid / dbg_cmd_ready  in/out  1  command handshake
- dbg_cmd_write  in  1  1 = write burst, 0 = read burst
- dbg_cmd_addr  in  ADDR_W  burst start word address
- dbg_cmd_len  in  LEN_W  burst length in words
- dbg_wdata_valid / dbg_wdata_ready  in/out  1  write-data handshake
- dbg_wdata  in  DATA_W  write data
- dbg_rdata_valid  out  1  read-data strobe (no backpressure)
- dbg_rdata  out  DATA_W  read data
- dbg_done  out  1  one-cycle pulse at burst end
- mem_read / mem_write  out  1  to datamemory MemRead / MemWrite
- mem_a  out  ADDR_W  to datamemory a
- mem_wd / mem_wd2  out  DATA_W  to datamemory wd / wd2
- mem_funct3  out  3  to datamemory Funct3
- mem_enable_halt  out  1  pair-write mode: wd goes to a, wd2 goes to a+1
- mem_rd  in  DATA_W  from datamemory rd

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; core_stall=0, dbg_halted=0, dbg_cmd_ready=0, dbg_wdata_ready=0, dbg_rdata_valid=0, dbg_done=0.
  - mem_read=0, mem_write=0, mem_enable_halt=0, mem_a=0, mem_wd=0, mem_wd2=0, mem_funct3=0.
  - A burst in progress is abandoned with no dbg_done.
- RUN:
  - mem_* mirror core_* combinationally; mem_enable_halt=0; core_rdata=mem_rd.
  - dbg_halt_req=1 -> HALTED next edge. A core access in that same cycle completes normally.
- HALTED:
  - core_stall=1, dbg_halted=1, dbg_cmd_ready=1; memory port idle.
  - cmd accept: latch addr/len/write. len=0 -> DONE. write -> WR_COLLECT. read -> RD_ISSUE.
  - dbg_halt_req=0 with no command -> RUN next edge; core_stall and dbg_halted drop on that edge.
- WR_COLLECT:
  - dbg_wdata_ready=1.
  - First accepted word is held.
  - If remaining=1, issue a single SW (funct3=010, enable_halt=0) at addr.
  - Otherwise accept a second word, then WR_ISSUE.
- WR_ISSUE (1 cycle):
  - mem_write=1, funct3=010, enable_halt=1, a=addr, wd=word0, wd2=word1; dbg_wdata_ready=0.
  - addr+=2 (wraps), remaining-=2.
  - Next state is WR_COLLECT, or DONE when remaining=0.
  - Write bursts therefore run at ≤1 pair per 3 cycles with a continuously valid source.
- RD_ISSUE:
  - mem_read=1, funct3=010 every cycle; addr+=1 (wraps).
  - mem_rd is captured 1 cycle later into dbg_rdata with dbg_rdata_valid=1 (read latency 1).
  - After the last issue, the final word returns, then DONE.
- DONE:
  - dbg_done=1 for one cycle.
  - Next state is HALTED if dbg_halt_req=1, else RUN.
  - Deasserting dbg_halt_req mid-burst does not abort the burst.
- Other rules:
  - Core requests while core_stall=1 are ignored.
  - The address of a pair write at 2^ADDR_W−1 wraps to 0 for the second word; the memory performs that wrap.
  - Debug writes are always full-word; no SB/SH in debug mode.

Decomposition:
- dmem_ctrl_pkg:
  - state enum: RUN, HALTED, WR_COLLECT, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE.
  - funct3 constants: LB=000, LH=001, LW/SW=010, LBU=100, LHU=101.
- One sub-module: dmem_burst_counter (address and remaining counters, wrap, last flag).

Test Plan:
- RUN passthrough: core SW addr 5 data 0xDEADBEEF, then LW addr 5 -> mem_* mirror core, core_rdata=0xDEADBEEF, core_stall=0 throughout.
- Halt handshake: core LW in the same cycle dbg_halt_req rises -> that LW completes; core_stall=1 and dbg_halted=1 next edge; mem idle.
- Write burst addr 10, len 5, data 1..5:
  - two pair writes: a=10 (wd=1, wd2=2), a=12 (wd=3, wd2=4), each with enable_halt=1;
  - then a single SW a=14, wd=5, enable_halt=0;
  - dbg_done pulses once.
- Read burst addr 510, len 4 -> mem_a sequence 510, 511, 0, 1; four dbg_rdata_valid pulses, each one cycle after its issue; dbg_done after the last.
- len=0 command -> no mem access, dbg_done one cycle after accept. Release halt -> RUN, core_stall=0.
- rst_n low mid write burst -> all outputs at reset values immediately; after release state=RUN and no dbg_done.
